goldschmidt_div_seq: RTL and testbench

//  Client-facing sequencer and result consumer for the iterative Goldschmidt divide datapath.
//  - Accepts one operand pair per valid/ready handshake.
//  - Drives the datapath's mode/stage/rem schedule and holds the operands stable.
//  - Reads back the quotient and the remainder-sign/remainder-zero flags.
//  - Returns a correctly rounded quotient on a valid/ready output port.
//  - Sits between the divide client and goldschmidt_div and replaces the free-running controller.

---
 rtl/goldschmidt_pkg.sv | 28 ++
 rtl/goldschmidt_round.sv | 28 ++
 rtl/goldschmidt_div_seq.sv | 126 ++++++++++++
 tb/tb_goldschmidt_div_seq.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/goldschmidt_pkg.sv
// Shared types and schedule constants for the Goldschmidt divide sequencer.
// ctrl_for() maps an iteration count onto the datapath control triple.
package goldschmidt_pkg;

  typedef enum logic [1:0] {IDLE, ITER, FLAG, HOLD} state_t;
  typedef enum logic {RND_RZ, RND_RU} rnd_t;

  localparam int ITER_CYCLES = 12;
  localparam int REM_CYCLE   = ITER_CYCLES - 1;
  localparam int MODE_FIRST  = 2;
  localparam int MODE_LAST   = 10;
  localparam int CNT_W       = 4;

  typedef struct packed {
    logic mode;
    logic stage;
    logic rem;
  } dp_ctrl_t;

  function automatic dp_ctrl_t ctrl_for(input logic [CNT_W-1:0] cnt);
    dp_ctrl_t c;
    c.stage = cnt[0];
    c.mode  = (int'(cnt) >= MODE_FIRST) && (int'(cnt) <= MODE_LAST);
    c.rem   = (int'(cnt) == REM_CYCLE);
    return c;
  endfunction

endpackage

// File: rtl/goldschmidt_round.sv
// Combinational rounding of the truncated quotient using the remainder flags.
// Decrement clamps at zero and increment saturates at all ones.
module goldschmidt_round
  import goldschmidt_pkg::*;
#(
  parameter int QW = 27
) (
  input  logic [QW-1:0] t,
  input  logic          rem_sign,
  input  logic          rem_zero,
  input  rnd_t          rnd,
  output logic [QW-1:0] q,
  output logic          inexact
);

  always_comb begin
    q = t;
    if (rnd == RND_RZ) begin
      // Truncated quotient overshot the true value: step back one ulp.
      if (rem_sign && (t != '0)) q = t - QW'(1);
    end else begin
      if (!(rem_sign || rem_zero) && (t != '1)) q = t + QW'(1);
    end
  end

  assign inexact = ~rem_zero;

endmodule

// File: rtl/goldschmidt_div_seq.sv
// Client-facing sequencer for the iterative Goldschmidt divider: drives the
// 12-cycle datapath schedule, then rounds and holds the result on a valid/ready port.
module goldschmidt_div_seq
  import goldschmidt_pkg::*;
#(
  parameter int WIDTH = 30,
  parameter int GUARD = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_num,
  input  logic [WIDTH-1:0]       in_den,
  input  logic                   in_rnd,
  output logic                   dp_mode,
  output logic                   dp_stage,
  output logic                   dp_rem,
  output logic [WIDTH-1:0]       dp_numerator,
  output logic [WIDTH-1:0]       dp_denominator,
  input  logic [WIDTH-1:0]       dp_quotient,
  input  logic                   dp_rem_sign,
  input  logic                   dp_rem_zero,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-GUARD-1:0] out_quotient,
  output logic                   out_inexact,
  output logic                   out_dz
);

  localparam int QW = WIDTH - GUARD;

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  dp_ctrl_t         r_ctrl;
  logic [WIDTH-1:0] r_num;
  logic [WIDTH-1:0] r_den;
  rnd_t             r_rnd;
  logic [QW-1:0]    r_q;
  logic             r_inexact;
  logic             r_dz;

  logic [QW-1:0]    w_q;
  logic             w_inexact;
  logic             w_accept;
  logic             w_unused_guard;

  // Guard bits only exist to make the datapath's remainder flags meaningful.
  assign w_unused_guard = ^dp_quotient[GUARD-1:0];

  assign in_ready = (r_state == IDLE) || ((r_state == HOLD) && out_ready);
  assign w_accept = in_valid && in_ready;

  goldschmidt_round #(.QW(QW)) u_round (
    .t        (dp_quotient[WIDTH-1:GUARD]),
    .rem_sign (dp_rem_sign),
    .rem_zero (dp_rem_zero),
    .rnd      (r_rnd),
    .q        (w_q),
    .inexact  (w_inexact)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_ctrl    <= '0;
      r_num     <= '0;
      r_den     <= '0;
      r_rnd     <= RND_RZ;
      r_q       <= '0;
      r_inexact <= 1'b0;
      r_dz      <= 1'b0;
    end else begin
      r_ctrl <= '0;
      case (r_state)
        IDLE, HOLD: begin
          if (w_accept) begin
            r_num   <= in_num;
            r_den   <= in_den;
            r_rnd   <= rnd_t'(in_rnd);
            r_count <= '0;
            if (in_den == '0) begin
              r_state   <= HOLD;
              r_q       <= '1;
              r_inexact <= 1'b0;
              r_dz      <= 1'b1;
            end else begin
              r_state <= ITER;
              r_dz    <= 1'b0;
              r_ctrl  <= ctrl_for('0);
            end
          end else if ((r_state == HOLD) && out_ready) begin
            r_state <= IDLE;
          end
        end
        ITER: begin
          if (r_count == CNT_W'(REM_CYCLE)) begin
            r_state <= FLAG;
          end else begin
            r_count <= r_count + CNT_W'(1);
            r_ctrl  <= ctrl_for(r_count + CNT_W'(1));
          end
        end
        FLAG: begin
          r_q       <= w_q;
          r_inexact <= w_inexact;
          r_dz      <= 1'b0;
          r_state   <= HOLD;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign dp_mode        = r_ctrl.mode;
  assign dp_stage       = r_ctrl.stage;
  assign dp_rem         = r_ctrl.rem;
  assign dp_numerator   = r_num;
  assign dp_denominator = r_den;
  assign out_valid      = (r_state == HOLD);
  assign out_quotient   = r_q;
  assign out_inexact    = r_inexact;
  assign out_dz         = r_dz;

endmodule

// File: tb/tb_goldschmidt_div_seq.sv
// Bench for goldschmidt_div_seq: the bench plays the datapath, supplying quotient
// and remainder flags, and checks schedule, rounding, handshake and reset behaviour.
module tb_goldschmidt_div_seq;

  localparam int WIDTH = 30;
  localparam int GUARD = 3;
  localparam int QW    = WIDTH - GUARD;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_num;
  logic [WIDTH-1:0] in_den;
  logic             in_rnd;
  logic             dp_mode;
  logic             dp_stage;
  logic             dp_rem;
  logic [WIDTH-1:0] dp_numerator;
  logic [WIDTH-1:0] dp_denominator;
  logic [WIDTH-1:0] dp_quotient;
  logic             dp_rem_sign;
  logic             dp_rem_zero;
  logic             out_valid;
  logic             out_ready;
  logic [QW-1:0]    out_quotient;
  logic             out_inexact;
  logic             out_dz;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  goldschmidt_div_seq #(.WIDTH(WIDTH), .GUARD(GUARD)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_num         (in_num),
    .in_den         (in_den),
    .in_rnd         (in_rnd),
    .dp_mode        (dp_mode),
    .dp_stage       (dp_stage),
    .dp_rem         (dp_rem),
    .dp_numerator   (dp_numerator),
    .dp_denominator (dp_denominator),
    .dp_quotient    (dp_quotient),
    .dp_rem_sign    (dp_rem_sign),
    .dp_rem_zero    (dp_rem_zero),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_quotient   (out_quotient),
    .out_inexact    (out_inexact),
    .out_dz         (out_dz)
  );

  // Reference rounding from the arithmetic rules on plain integers.
  function automatic longint ref_q(input longint t, input bit sign, input bit zero, input bit ru);
    longint maxv;
    maxv = (longint'(1) << QW) - 1;
    if (!ru) return sign ? ((t > 0) ? t - 1 : 0) : t;
    return (sign || zero) ? t : ((t < maxv) ? t + 1 : maxv);
  endfunction

  // Runs one operation from IDLE and reports what was observed; callers do the checking.
  task automatic run_op(input logic [WIDTH-1:0] num, input logic [WIDTH-1:0] den, input bit ru,
                        input logic [QW-1:0] t, input bit sign, input bit zero,
                        output int lat, output int rem_pulses, output int mode_cycles,
                        output int any_cycles, output int dp_changed,
                        output logic [QW-1:0] q, output logic inexact, output logic dz);
    lat = -1; rem_pulses = 0; mode_cycles = 0; any_cycles = 0; dp_changed = 0;
    @(negedge clk);
    in_valid = 1'b1; in_num = num; in_den = den; in_rnd = ru;
    dp_quotient = {t, GUARD'($urandom)}; dp_rem_sign = sign; dp_rem_zero = zero;
    @(posedge clk); #1;
    in_valid = 1'b0; in_num = WIDTH'($urandom); in_den = WIDTH'($urandom); in_rnd = ~ru;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      rem_pulses  += int'(dp_rem);
      mode_cycles += int'(dp_mode);
      any_cycles  += int'(dp_mode | dp_stage | dp_rem);
      if (k <= 13 && (dp_numerator !== num || dp_denominator !== den)) dp_changed++;
      if (out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    q = out_quotient; inexact = out_inexact; dz = out_dz;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_num = '0; in_den = '0; in_rnd = 1'b0;
    out_ready = 1'b0; dp_quotient = '0; dp_rem_sign = 1'b0; dp_rem_zero = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({in_ready, out_valid, dp_mode, dp_stage, dp_rem} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_ctrl got={rdy,vld,mode,stage,rem}=%b exp=10000",
               {in_ready, out_valid, dp_mode, dp_stage, dp_rem});
    end
    n_tests++;
    if (out_quotient !== '0 || out_inexact !== 1'b0 || out_dz !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_result got q=%h inexact=%b dz=%b exp q=0 inexact=0 dz=0",
               out_quotient, out_inexact, out_dz);
    end
    n_tests++;
    if (dp_numerator !== '0 || dp_denominator !== '0) begin
      n_fail++;
      $display("FAIL reset_operands got num=%h den=%h exp 0/0", dp_numerator, dp_denominator);
    end
  endtask

  task automatic test_schedule();
    logic [WIDTH-1:0] num;
    logic [WIDTH-1:0] den;
    logic [3:0]       got;
    logic [3:0]       exp;
    int               c;
    num = {1'b1, 29'($urandom)};
    den = 30'h3000_0000;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL sched_idle_ready got=%b exp=1", in_ready);
    end
    in_valid = 1'b1; in_num = num; in_den = den; in_rnd = 1'b0;
    dp_quotient = {27'h1000, 3'b101}; dp_rem_sign = 1'b0; dp_rem_zero = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_num = '0; in_den = '0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      c = k - 1;
      if (k <= 12) exp = {c >= 2 && c <= 10, c % 2 == 1, c == 11, 1'b0};
      else         exp = {3'b000, k >= 14};
      got = {dp_mode, dp_stage, dp_rem, out_valid};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL sched_cycle_%0d got={mode,stage,rem,vld}=%b exp=%b", k, got, exp);
      end
      if (k <= 13) begin
        n_tests++;
        if (dp_numerator !== num || dp_denominator !== den) begin
          n_fail++;
          $display("FAIL sched_operands_%0d got num=%h den=%h exp num=%h den=%h",
                   k, dp_numerator, dp_denominator, num, den);
        end
      end
    end
    n_tests++;
    if (out_quotient !== 27'h1000 || out_inexact !== 1'b0 || out_dz !== 1'b0) begin
      n_fail++;
      $display("FAIL sched_result got q=%h inexact=%b dz=%b exp q=1000 inexact=0 dz=0",
               out_quotient, out_inexact, out_dz);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // Shared body for directed and random rounding ops: runs the op and checks everything observed.
  task automatic check_round_op(input string name, input logic [QW-1:0] t, input bit sign,
                                input bit zero, input bit ru);
    int lat, remp, modec, anyc, chg;
    logic [QW-1:0] q;
    logic inexact, dz;
    logic [QW-1:0] exp_q;
    exp_q = QW'(ref_q(longint'(t), sign, zero, ru));
    run_op({1'b1, 29'($urandom)}, {1'b1, 29'($urandom)}, ru, t, sign, zero,
           lat, remp, modec, anyc, chg, q, inexact, dz);
    n_tests++;
    if (q !== exp_q || inexact !== ~zero || dz !== 1'b0) begin
      n_fail++;
      $display("FAIL %s t=%h s=%0d z=%0d ru=%0d got q=%h inexact=%b dz=%b exp q=%h inexact=%b dz=0",
               name, t, sign, zero, ru, q, inexact, dz, exp_q, ~zero);
    end
    n_tests++;
    if (lat != 14 || remp != 1 || modec != 9 || anyc != 11 || chg != 0) begin
      n_fail++;
      $display("FAIL %s_sched got lat=%0d rem=%0d mode=%0d ctrl=%0d opchg=%0d exp 14/1/9/11/0",
               name, lat, remp, modec, anyc, chg);
    end
    $display("[TB] %s t=%h s=%0d z=%0d ru=%0d -> q=%h inexact=%b lat=%0d",
             name, t, sign, zero, ru, q, inexact, lat);
  endtask

  task automatic test_rounding();
    for (int ru = 0; ru < 2; ru++) begin
      check_round_op("round_s1z0", 27'h1000, 1'b1, 1'b0, ru[0]);
      check_round_op("round_s0z1", 27'h1000, 1'b0, 1'b1, ru[0]);
      check_round_op("round_s0z0", 27'h1000, 1'b0, 1'b0, ru[0]);
    end
  endtask

  task automatic test_random();
    logic [QW-1:0] t;
    logic [1:0]    flags;
    for (int i = 0; i < 20; i++) begin
      case ($urandom_range(0, 5))
        0:       t = '0;
        1:       t = '1;
        default: t = QW'($urandom);
      endcase
      // (sign, zero) = (1,1) cannot occur, so draw from the three legal pairs.
      case ($urandom_range(0, 2))
        0:       flags = 2'b10;
        1:       flags = 2'b01;
        default: flags = 2'b00;
      endcase
      check_round_op("round_rand", t, flags[1], flags[0], 1'($urandom));
    end
  endtask

  task automatic test_saturation();
    check_round_op("sat_ru_max", '1, 1'b0, 1'b0, 1'b1);
    check_round_op("clamp_rz_zero", '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_div_zero();
    int lat, remp, modec, anyc, chg;
    logic [QW-1:0] q;
    logic inexact, dz;
    run_op({1'b1, 29'($urandom)}, '0, 1'b1, QW'($urandom), 1'b0, 1'b0,
           lat, remp, modec, anyc, chg, q, inexact, dz);
    n_tests++;
    if (q !== '1 || dz !== 1'b1 || inexact !== 1'b0) begin
      n_fail++;
      $display("FAIL dz_result got q=%h dz=%b inexact=%b exp q=%h dz=1 inexact=0",
               q, dz, inexact, {QW{1'b1}});
    end
    n_tests++;
    if (lat != 1 || anyc != 0) begin
      n_fail++;
      $display("FAIL dz_timing got lat=%0d ctrl_cycles=%0d exp lat=1 ctrl_cycles=0", lat, anyc);
    end
    $display("[TB] dz -> q=%h dz=%b lat=%0d", q, dz, lat);
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] num2;
    logic [QW-1:0]    t1, t2, exp1, exp2;
    int               lat;
    t1 = QW'($urandom); t2 = QW'($urandom);
    exp1 = QW'(ref_q(longint'(t1), 1'b1, 1'b0, 1'b0));
    exp2 = QW'(ref_q(longint'(t2), 1'b0, 1'b0, 1'b1));
    num2 = {1'b1, 29'($urandom)};
    @(negedge clk);
    in_valid = 1'b1; in_num = {1'b1, 29'($urandom)}; in_den = {1'b1, 29'($urandom)}; in_rnd = 1'b0;
    dp_quotient = {t1, 3'b000}; dp_rem_sign = 1'b1; dp_rem_zero = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin lat = k; break; end
    end
    n_tests++;
    if (lat != 14) begin
      n_fail++;
      $display("FAIL b2b_first_latency got=%0d exp=14", lat);
    end
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_quotient !== exp1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_hold_%0d got vld=%b q=%h rdy=%b exp vld=1 q=%h rdy=0",
                 i, out_valid, out_quotient, in_ready, exp1);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid = 1'b1; in_num = num2; in_den = {1'b1, 29'($urandom)}; in_rnd = 1'b1;
    dp_quotient = {t2, 3'b111}; dp_rem_sign = 1'b0; dp_rem_zero = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready_on_consume got=%b exp=1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        n_tests++;
        if (out_valid !== 1'b0 || dp_numerator !== num2) begin
          n_fail++;
          $display("FAIL b2b_restart got vld=%b num=%h exp vld=0 num=%h", out_valid, dp_numerator, num2);
        end
      end
      if (out_valid === 1'b1) begin lat = k; break; end
    end
    n_tests++;
    if (lat != 14 || out_quotient !== exp2 || out_inexact !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second got lat=%0d q=%h inexact=%b exp lat=14 q=%h inexact=1",
               lat, out_quotient, out_inexact, exp2);
    end
    $display("[TB] b2b second -> q=%h lat=%0d", out_quotient, lat);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int vld_seen;
    @(negedge clk);
    in_valid = 1'b1; in_num = {1'b1, 29'($urandom)}; in_den = {1'b1, 29'($urandom)}; in_rnd = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    n_tests++;
    if ({dp_mode, dp_stage, dp_rem} !== 3'b100) begin
      n_fail++;
      $display("FAIL rstmid_count6 got={mode,stage,rem}=%b exp=100", {dp_mode, dp_stage, dp_rem});
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({in_ready, out_valid, dp_mode, dp_stage, dp_rem} !== 5'b10000) begin
      n_fail++;
      $display("FAIL rstmid_idle got={rdy,vld,mode,stage,rem}=%b exp=10000",
               {in_ready, out_valid, dp_mode, dp_stage, dp_rem});
    end
    vld_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      vld_seen += int'(out_valid === 1'b1);
    end
    n_tests++;
    if (vld_seen != 0) begin
      n_fail++;
      $display("FAIL rstmid_no_result got out_valid cycles=%0d exp=0", vld_seen);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_schedule();
    test_rounding();
    test_saturation();
    test_random();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
